// File: rtl/division_secuencial_if.sv
// Start/done handshake bundle between the ALU sequencer and the sequential divider.
interface division_secuencial_if #(
    parameter int M = 4
);
    logic         start;
    logic [M-1:0] input1;
    logic [M-1:0] input2;
    logic [M-1:0] quotient;
    logic [M-1:0] remainder;
    logic         busy;
    logic         done;
    logic         DivZero;

    modport master (
        output start, input1, input2,
        input  quotient, remainder, busy, done, DivZero
    );

    modport slave (
        input  start, input1, input2,
        output quotient, remainder, busy, done, DivZero
    );
endinterface

// File: rtl/division_secuencial.sv
// Restoring shift-subtract unsigned divider: one quotient bit per clock, M iterations per operation.
module division_secuencial #(
    parameter int M = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    division_secuencial_if.slave bus
);
    localparam int CW = $clog2(M + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [M-1:0]   dvd, dvd_n;    // dividend shifts out the top, quotient bits enter the bottom
    logic [M-1:0]   prem, prem_n;  // partial remainder, always < divisor between iterations
    logic [M-1:0]   dvs, dvs_n;
    logic [M-1:0]   quo_r, quo_n;
    logic [M-1:0]   rem_r, rem_n;
    logic           done_r, done_n;
    logic           dz_r, dz_n;

    logic [M:0]     shifted;
    logic [M:0]     trial;
    logic           ge;
    logic [M-1:0]   prem_step;
    logic [M-1:0]   dvd_step;

    // shifted < 2*divisor, so the M+1-bit trial cannot wrap; its top bit is the sign.
    assign shifted   = {prem, dvd[M-1]};
    assign trial     = shifted - {1'b0, dvs};
    assign ge        = ~trial[M];
    assign prem_step = ge ? trial[M-1:0] : shifted[M-1:0];
    assign dvd_step  = {dvd[M-2:0], ge};

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dvd_n   = dvd;
        prem_n  = prem;
        dvs_n   = dvs;
        quo_n   = quo_r;
        rem_n   = rem_r;
        dz_n    = dz_r;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.input2 == '0) begin
                        quo_n  = '1;
                        rem_n  = bus.input1;
                        dz_n   = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        dvd_n   = bus.input1;
                        prem_n  = '0;
                        dvs_n   = bus.input2;
                        cnt_n   = CW'(M);
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                dvd_n  = dvd_step;
                prem_n = prem_step;
                cnt_n  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    quo_n   = dvd_step;
                    rem_n   = prem_step;
                    dz_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            prem   <= '0;
            dvs    <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            dvd    <= dvd_n;
            prem   <= prem_n;
            dvs    <= dvs_n;
            quo_r  <= quo_n;
            rem_r  <= rem_n;
            done_r <= done_n;
            dz_r   <= dz_n;
        end
    end

    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign bus.busy      = (state == CALC);
    assign bus.done      = done_r;
    assign bus.DivZero   = dz_r;
endmodule

// File: tb/tb_division_secuencial.sv
// Scoreboard bench for division_secuencial: driver pushes expected results, negedge monitor checks them.
module tb_division_secuencial;
    localparam int M = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    division_secuencial_if #(.M(M)) bus ();

    division_secuencial #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [M-1:0] q;
        logic [M-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    logic [M-1:0] last_q  = '0;
    logic [M-1:0] last_r  = '0;
    logic         last_dz = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer division; divide-by-zero yields all-ones quotient and the dividend back.
    task automatic push(input logic [M-1:0] a, input logic [M-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.due = cyc + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.due = cyc + 1 + M;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_busy;
        exp_busy = sb.size() > 0 && !sb[0].dz && cyc >= sb[0].due - M && cyc < sb[0].due;
        check("busy", bus.busy, exp_busy);
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", bus.done, 0);
            end else begin
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("DivZero", bus.DivZero, e.dz);
                check("latency", cyc, e.due);
                last_q = e.q; last_r = e.r; last_dz = e.dz;
            end
        end else begin
            check("hold_quotient", bus.quotient, last_q);
            check("hold_remainder", bus.remainder, last_r);
            check("hold_DivZero", bus.DivZero, last_dz);
        end
    end

    task automatic wait_done();
        for (int i = 0; i < M + 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) return;
        end
        check("done_timeout", bus.done, 1);
    endtask

    task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.input1 = a;
        bus.input2 = b;
        push(a, b);
        wait_done();
    endtask

    // start held high with scrambled operands during CALC, then a second op accepted in the done cycle.
    task automatic hold_and_chain();
        bit seen = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.input1 = 4'd14;
        bus.input2 = 4'd4;
        push(4'd14, 4'd4);
        for (int i = 0; i < M + 3 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else begin
                bus.input1 = M'($urandom);
                bus.input2 = M'($urandom);
            end
        end
        check("hold_done_seen", bus.done, 1);
        bus.input1 = 4'd7;
        bus.input2 = 4'd2;
        push(4'd7, 4'd2);
        wait_done();
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.input1 = 4'd11;
        bus.input2 = 4'd2;
        push(4'd11, 4'd2);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        sb.delete();
        last_q = '0; last_r = '0; last_dz = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_DivZero", bus.DivZero, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(4'd11, 4'd2);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.input1 = '0;
        bus.input2 = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(4'd13, 4'd3);
        run_op(4'd15, 4'd15);
        run_op(4'd15, 4'd1);
        run_op(4'd0, 4'd5);
        run_op(4'd2, 4'd7);
        run_op(4'd9, 4'd0);
        repeat (3) @(negedge clk);
        run_op(4'd6, 4'd2);
        hold_and_chain();
        repeat (2) @(negedge clk);
        reset_mid_op();

        for (int a = 0; a < (1 << M); a++)
            for (int b = 1; b < (1 << M); b++)
                run_op(M'(a), M'(b));

        for (int i = 0; i < 60; i++) begin
            run_op(M'($urandom), M'($urandom_range(0, (1 << M) - 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
